// File: rtl/linear_layer_i4xi4_q_start_fifo.sv
// ---------------------------------------------------------------------------
// linear_layer_i4xi4_q_start_fifo
//
// Start-token FIFO between a producing dataflow process and a consuming
// PE_i4xi4_pack_2x2. Storage is a shift register (SRL) of DEPTH-1 entries
// followed by one registered head-of-queue stage, giving a first-word-fall-
// through read port. Every output comes straight from a flop.
//
// Optional feature (define the macro to enable):
//   LINEAR_LAYER_START_FIFO_NUM_VALID_EN -> adds if_num_data_valid (occupancy)
//
// Parameters:
//   DATA_WIDTH  token width in bits
//   ADDR_WIDTH  SRL index width, 2**ADDR_WIDTH >= DEPTH
//   DEPTH       total capacity in tokens (>= 2)
//
// Ports:
//   clk                 rising-edge clock
//   reset               asynchronous, active-high reset
//   if_full_n      out  1 = space available
//   if_write_ce    in   write clock enable
//   if_write       in   write request
//   if_din         in   write data
//   if_empty_n     out  1 = if_dout holds a valid token
//   if_read_ce     in   read clock enable
//   if_read        in   read request (pop)
//   if_dout        out  head token (registered)
//   if_num_data_valid out  tokens held (macro builds only)
// ---------------------------------------------------------------------------
module linear_layer_i4xi4_q_start_fifo #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  if_full_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_empty_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout
`ifdef LINEAR_LAYER_START_FIFO_NUM_VALID_EN
  ,
  output logic [ADDR_WIDTH:0]   if_num_data_valid
`endif
);

  localparam int                SRL_DEPTH  = DEPTH - 1;
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_srl [SRL_DEPTH];
  logic [ADDR_WIDTH-1:0] r_srl_cnt;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_full_n;
  logic                  r_dout_vld;
  logic [DATA_WIDTH-1:0] r_dout;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_load;
  logic                  w_from_srl;
  logic                  w_bypass;
  logic                  w_srl_wr;
  logic [DATA_WIDTH-1:0] w_srl_head;
  logic [ADDR_WIDTH:0]   w_count_nxt;

  // Handshakes are qualified by the registered flags, so requests made while
  // full or empty simply have no effect.
  assign w_push = if_write_ce & if_write & r_full_n;
  assign w_pop  = if_read_ce  & if_read  & r_dout_vld;

  // The head register refills whenever it is empty or being popped. The SRL
  // always has priority: if it holds tokens they are older than if_din.
  assign w_load     = ~r_dout_vld | w_pop;
  assign w_from_srl = w_load & (r_srl_cnt != '0);
  assign w_bypass   = w_load & (r_srl_cnt == '0) & w_push;
  assign w_srl_wr   = w_push & ~w_bypass;

  assign w_count_nxt = r_count + (ADDR_WIDTH + 1)'(w_push)
                               - (ADDR_WIDTH + 1)'(w_pop);

  // Oldest SRL entry sits at index srl_cnt-1; a compare-per-entry mux keeps
  // the select width independent of the SRL length.
  always_comb begin
    // NOTE: default assignment first so no path through the block leaves
    // w_srl_head unassigned, which would infer a latch.
    w_srl_head = '0;
    for (int i = 0; i < SRL_DEPTH; i++) begin
      if (r_srl_cnt == ADDR_WIDTH'(i + 1)) w_srl_head = r_srl[i];
    end
  end

  // NOTE: the shift-register storage has no reset; its contents are
  // meaningless until srl_cnt says otherwise, and leaving the reset off lets
  // it map onto SRL/LUT-RAM primitives.
  always_ff @(posedge clk) begin
    if (w_srl_wr) begin
      r_srl[0] <= if_din;
      for (int i = 1; i < SRL_DEPTH; i++) begin
        r_srl[i] <= r_srl[i-1];
      end
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count    <= '0;
      r_srl_cnt  <= '0;
      r_full_n   <= 1'b1;
      r_dout_vld <= 1'b0;
      r_dout     <= '0;
    end else begin
      r_count   <= w_count_nxt;
      r_full_n  <= (w_count_nxt != FULL_COUNT);
      r_srl_cnt <= r_srl_cnt + ADDR_WIDTH'(w_srl_wr) - ADDR_WIDTH'(w_from_srl);
      if (w_load) begin
        r_dout_vld <= w_from_srl | w_bypass;
        // With nothing to load the last token stays on if_dout.
        if (w_from_srl)    r_dout <= w_srl_head;
        else if (w_bypass) r_dout <= if_din;
      end
    end
  end

  assign if_full_n  = r_full_n;
  assign if_empty_n = r_dout_vld;
  assign if_dout    = r_dout;

`ifdef LINEAR_LAYER_START_FIFO_NUM_VALID_EN
  assign if_num_data_valid = r_count;
`endif

endmodule

// File: tb/tb_linear_layer_i4xi4_q_start_fifo.sv
// ---------------------------------------------------------------------------
// Bench for linear_layer_i4xi4_q_start_fifo. Three instances share one set of
// write/read controls: A (defaults: 1-bit, DEPTH 2), B (8-bit, DEPTH 2) and
// C (8-bit, DEPTH 4). Each is tracked by a queue model of an ideal FIFO.
// ---------------------------------------------------------------------------
module tb_linear_layer_i4xi4_q_start_fifo;

  localparam int DA = 2;
  localparam int DB = 2;
  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       wce, wr, rce, rd;
  logic [7:0] din;

  logic       full_a, empty_a;
  logic [0:0] dout_a;
  logic       full_b, empty_b;
  logic [7:0] dout_b;
  logic       full_c, empty_c;
  logic [7:0] dout_c;
`ifdef LINEAR_LAYER_START_FIFO_NUM_VALID_EN
  logic [2:0] nv_c;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: ideal FIFOs plus the last head seen on each output.
  logic       qa[$];
  logic [7:0] qb[$];
  logic [7:0] qc[$];
  logic       ha;
  logic [7:0] hb, hc;

  always #5 clk = ~clk;

  linear_layer_i4xi4_q_start_fifo u_dut_a (
    .clk(clk), .reset(reset),
    .if_full_n(full_a), .if_write_ce(wce), .if_write(wr), .if_din(din[0:0]),
    .if_empty_n(empty_a), .if_read_ce(rce), .if_read(rd), .if_dout(dout_a)
  );

  linear_layer_i4xi4_q_start_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(1), .DEPTH(DB)) u_dut_b (
    .clk(clk), .reset(reset),
    .if_full_n(full_b), .if_write_ce(wce), .if_write(wr), .if_din(din),
    .if_empty_n(empty_b), .if_read_ce(rce), .if_read(rd), .if_dout(dout_b)
  );

  linear_layer_i4xi4_q_start_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .DEPTH(DC)) u_dut_c (
`ifdef LINEAR_LAYER_START_FIFO_NUM_VALID_EN
    .if_num_data_valid(nv_c),
`endif
    .clk(clk), .reset(reset),
    .if_full_n(full_c), .if_write_ce(wce), .if_write(wr), .if_din(din),
    .if_empty_n(empty_c), .if_read_ce(rce), .if_read(rd), .if_dout(dout_c)
  );

  task automatic model_reset();
    qa.delete(); qb.delete(); qc.delete();
    ha = 1'b0; hb = 8'h00; hc = 8'h00;
  endtask

  // Ideal FIFO step: accept a push only below capacity, a pop only when
  // non-empty, both decided on the occupancy before the edge.
  task automatic model_edge();
    bit pa, pb, pc, oa, ob, oc;
    pa = wce && wr && (qa.size() < DA);  oa = rce && rd && (qa.size() > 0);
    pb = wce && wr && (qb.size() < DB);  ob = rce && rd && (qb.size() > 0);
    pc = wce && wr && (qc.size() < DC);  oc = rce && rd && (qc.size() > 0);
    if (oa) void'(qa.pop_front());
    if (ob) void'(qb.pop_front());
    if (oc) void'(qc.pop_front());
    if (pa) qa.push_back(din[0]);
    if (pb) qb.push_back(din);
    if (pc) qc.push_back(din);
    if (qa.size() > 0) ha = qa[0];
    if (qb.size() > 0) hb = qb[0];
    if (qc.size() > 0) hc = qc[0];
  endtask

  // Drive one cycle of controls, take the edge, update the model, and leave
  // the caller 1 time unit after the edge to sample outputs.
  task automatic step(input bit w_ce, input bit w, input bit r_ce, input bit r,
                      input logic [7:0] d);
    wce = w_ce; wr = w; rce = r_ce; rd = r; din = d;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    wce = 1'b0; wr = 1'b0; rce = 1'b0; rd = 1'b0; din = 8'h00;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    #12;
    checks++; if (full_a !== 1'b1)   begin errors++; $display("FAIL reset_full_a: got %b want 1", full_a); end
    checks++; if (empty_a !== 1'b0)  begin errors++; $display("FAIL reset_empty_a: got %b want 0", empty_a); end
    checks++; if (dout_a !== 1'b0)   begin errors++; $display("FAIL reset_dout_a: got %b want 0", dout_a); end
    checks++; if (full_c !== 1'b1)   begin errors++; $display("FAIL reset_full_c: got %b want 1", full_c); end
    checks++; if (empty_c !== 1'b0)  begin errors++; $display("FAIL reset_empty_c: got %b want 0", empty_c); end
    checks++; if (dout_c !== 8'h00)  begin errors++; $display("FAIL reset_dout_c: got %h want 00", dout_c); end
`ifdef LINEAR_LAYER_START_FIFO_NUM_VALID_EN
    checks++; if (nv_c !== 3'd0)     begin errors++; $display("FAIL reset_nv_c: got %0d want 0", nv_c); end
`endif
    reset = 1'b0;
    model_reset();
  endtask

  // First push after reset release lands on the first edge (instance A).
  task automatic test_single();
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h01);
    checks++; if (empty_a !== 1'b1) begin errors++; $display("FAIL single_empty_n: got %b want 1", empty_a); end
    checks++; if (dout_a !== 1'b1)  begin errors++; $display("FAIL single_dout: got %b want 1", dout_a); end
    checks++; if (full_a !== 1'b1)  begin errors++; $display("FAIL single_full_n: got %b want 1", full_a); end
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    checks++; if (empty_a !== 1'b0) begin errors++; $display("FAIL single_pop_empty_n: got %b want 0", empty_a); end
  endtask

  task automatic test_fill_overflow();
    logic [7:0] vals [4];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, vals[i]);
      checks++; if (full_c !== (i < 3)) begin errors++; $display("FAIL fill_full_n[%0d]: got %b want %b", i, full_c, (i < 3)); end
      checks++; if (dout_c !== 8'h11)   begin errors++; $display("FAIL fill_head[%0d]: got %h want 11", i, dout_c); end
`ifdef LINEAR_LAYER_START_FIFO_NUM_VALID_EN
      checks++; if (nv_c !== 3'(i + 1)) begin errors++; $display("FAIL fill_nv[%0d]: got %0d want %0d", i, nv_c, i + 1); end
`endif
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h55);
    checks++; if (full_c !== 1'b0) begin errors++; $display("FAIL overflow_full_n: got %b want 0", full_c); end
`ifdef LINEAR_LAYER_START_FIFO_NUM_VALID_EN
    checks++; if (nv_c !== 3'd4)   begin errors++; $display("FAIL overflow_nv: got %0d want 4", nv_c); end
`endif
    for (int i = 0; i < 4; i++) begin
      checks++; if (dout_c !== vals[i] || empty_c !== 1'b1) begin
        errors++; $display("FAIL drain_head[%0d]: got %h/%b want %h/1", i, dout_c, empty_c, vals[i]);
      end
      step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
      if (i == 0) begin
        checks++; if (full_c !== 1'b1) begin errors++; $display("FAIL drain_full_n: got %b want 1", full_c); end
`ifdef LINEAR_LAYER_START_FIFO_NUM_VALID_EN
        checks++; if (nv_c !== 3'd3)   begin errors++; $display("FAIL drain_nv: got %0d want 3", nv_c); end
`endif
      end
    end
    checks++; if (empty_c !== 1'b0) begin errors++; $display("FAIL drain_empty_n: got %b want 0", empty_c); end
  endtask

  task automatic test_streaming();
    do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 1; i <= 100; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b1, 8'(i));
      checks++; if (dout_c !== 8'(i) || empty_c !== 1'b1 || full_c !== 1'b1) begin
        errors++; $display("FAIL stream[%0d]: dout=%h empty_n=%b full_n=%b want %h/1/1", i, dout_c, empty_c, full_c, 8'(i));
      end
`ifdef LINEAR_LAYER_START_FIFO_NUM_VALID_EN
      checks++; if (nv_c !== 3'd1) begin errors++; $display("FAIL stream_nv[%0d]: got %0d want 1", i, nv_c); end
`endif
    end
  endtask

  // Instance B: push and pop together while full; the push must bounce.
  task automatic test_full_simultaneous();
    do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'hA1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'hA2);
    checks++; if (full_b !== 1'b0 || dout_b !== 8'hA1) begin
      errors++; $display("FAIL full2_state: full_n=%b dout=%h want 0/a1", full_b, dout_b);
    end
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'hAA);
    checks++; if (dout_b !== 8'hA2 || empty_b !== 1'b1 || full_b !== 1'b1) begin
      errors++; $display("FAIL full2_simul: dout=%h empty_n=%b full_n=%b want a2/1/1", dout_b, empty_b, full_b);
    end
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    checks++; if (empty_b !== 1'b0 || dout_b !== 8'hA2) begin
      errors++; $display("FAIL full2_drain: empty_n=%b dout=%h want 0/a2", empty_b, dout_b);
    end
  endtask

  // Reset asserted between edges must clear the outputs before the next edge.
  task automatic test_reset_mid();
    do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h5A);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h6B);
    wce = 1'b0; wr = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++; if (full_b !== 1'b1 || empty_b !== 1'b0 || dout_b !== 8'h00) begin
      errors++; $display("FAIL midreset_b: full_n=%b empty_n=%b dout=%h want 1/0/00", full_b, empty_b, dout_b);
    end
    checks++; if (full_c !== 1'b1 || empty_c !== 1'b0 || dout_c !== 8'h00) begin
      errors++; $display("FAIL midreset_c: full_n=%b empty_n=%b dout=%h want 1/0/00", full_c, empty_c, dout_c);
    end
    #1 reset = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      // Alternate write-heavy and read-heavy phases to visit full and empty.
      bit heavy_w;
      heavy_w = ((n / 40) % 2) == 0;
      step($urandom_range(0, 7) != 0,
           $urandom_range(0, 3) < (heavy_w ? 3 : 1),
           $urandom_range(0, 7) != 0,
           $urandom_range(0, 3) < (heavy_w ? 1 : 3),
           8'($urandom));
      checks++; if (empty_a !== (qa.size() > 0) || full_a !== (qa.size() < DA) || dout_a !== ha) begin
        errors++; $display("FAIL rand_a[%0d]: empty_n=%b full_n=%b dout=%b want %b/%b/%b", n, empty_a, full_a, dout_a, (qa.size() > 0), (qa.size() < DA), ha);
      end
      checks++; if (empty_b !== (qb.size() > 0) || full_b !== (qb.size() < DB) || dout_b !== hb) begin
        errors++; $display("FAIL rand_b[%0d]: empty_n=%b full_n=%b dout=%h want %b/%b/%h", n, empty_b, full_b, dout_b, (qb.size() > 0), (qb.size() < DB), hb);
      end
      checks++; if (empty_c !== (qc.size() > 0) || full_c !== (qc.size() < DC) || dout_c !== hc) begin
        errors++; $display("FAIL rand_c[%0d]: empty_n=%b full_n=%b dout=%h want %b/%b/%h", n, empty_c, full_c, dout_c, (qc.size() > 0), (qc.size() < DC), hc);
      end
`ifdef LINEAR_LAYER_START_FIFO_NUM_VALID_EN
      checks++; if (nv_c !== 3'(qc.size())) begin errors++; $display("FAIL rand_nv[%0d]: got %0d want %0d", n, nv_c, qc.size()); end
`endif
    end
  endtask

  initial begin
    reset = 1'b1;
    wce = 1'b0; wr = 1'b0; rce = 1'b0; rd = 1'b0; din = 8'h00;
    model_reset();
    test_reset();
    test_single();
    test_fill_overflow();
    test_streaming();
    test_full_simultaneous();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/linear_layer_i4xi4_q_start_fifo.md
# linear_layer_i4xi4_q_start_fifo

Start-token FIFO placed between a producing dataflow process and a consuming `PE_i4xi4_pack_2x2` instance. It wraps the shift-register storage with full/empty bookkeeping, an ap_fifo-style write/read handshake, and a registered head-of-queue output stage. The producer sees a plain FIFO write port and the consumer sees a first-word-fall-through read port. No output is driven combinationally from any input.

## Interface
- `DATA_WIDTH`, default 1: token width in bits.
- `ADDR_WIDTH`, default 1: SRL index width; 2^ADDR_WIDTH >= DEPTH.
- `DEPTH`, default 2: total capacity in tokens, >= 2 (DEPTH-1 SRL entries plus 1 output register).

- `clk` in, 1: single clock, rising edge.
- `reset` in, 1: asynchronous, active-high reset.
- `if_full_n` out, 1: 1 = space available.
- `if_write_ce` in, 1: write clock enable.
- `if_write` in, 1: write request.
- `if_din` in, DATA_WIDTH: write data.
- `if_empty_n` out, 1: 1 = `if_dout` holds a valid token.
- `if_read_ce` in, 1: read clock enable.
- `if_read` in, 1: read request (pop).
- `if_dout` out, DATA_WIDTH: head token; registered.

## Operation
- Definitions:
  - push = if_write_ce & if_write & if_full_n.
  - pop = if_read_ce & if_read & if_empty_n.
  - Requests while full or empty are ignored; they are not errors.
- State:
  - `count` ranges 0..DEPTH.
  - `srl_cnt` ranges 0..DEPTH-1.
  - `dout_vld` is the output-register valid bit.
  - if_empty_n = dout_vld.
  - if_full_n = (count != DEPTH).
- Occupancy phases:
  - EMPTY: count=0.
  - HEAD: count=1, SRL empty.
  - QUEUED: srl_cnt>0.
  - FULL: count=DEPTH.
- Output register load, when !dout_vld | pop:
  - If srl_cnt>0: load SRL[srl_cnt-1] (oldest entry), srl_cnt decrements.
  - Else if push: load if_din directly (bypass).
  - Else: dout_vld<=0. if_dout holds its last value.
- SRL write: push that is not taken by the bypass shifts if_din into SRL[0]. srl_cnt increments.
- Simultaneous push and pop:
  - count is unchanged.
  - The head advances and the new token enters the SRL (or the bypass when srl_cnt=0).
- Full: if_full_n=0, so a push in the same cycle as a pop is not accepted. There is no full pass-through.
- Empty: pop is impossible. A push makes the token visible the next cycle.
- Ordering is strict FIFO. No token is lost or duplicated across any push/pop combination.
- Reset, asynchronous and valid at any time including mid-transfer:
  - count=0, srl_cnt=0, dout_vld=0.
  - if_full_n=1, if_empty_n=0, if_dout=0.
  - SRL contents are not reset; they are don't-care.

## Timing
- Write-to-read latency is 1 cycle. A token pushed at edge N has if_empty_n=1 with that token on if_dout after edge N.
- Pop at edge N: the next head (or empty) is visible after edge N. Throughput is 1 token/cycle sustained.
- if_full_n deasserts after the edge that makes count=DEPTH. It reasserts after the first pop edge.
- Reset deassertion: the first push is accepted at the first rising edge with reset low.

## Configuration
- Macro: `LINEAR_LAYER_START_FIFO_NUM_VALID_EN`.
- Defined: adds output `if_num_data_valid` [ADDR_WIDTH:0].
  - Equals count, registered.
  - Reset value is 0.
  - Updates on the same edge as if_full_n and if_empty_n.
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset then idle: after reset, if_full_n=1, if_empty_n=0, if_dout=0. Assert reset mid-stream with 2 tokens held: outputs return to these values asynchronously, before the next edge.
- Single token, DEPTH=2, DATA_WIDTH=1:
  - Push 1 at edge 1: if_empty_n=1, if_dout=1 after edge 1.
  - Pop at edge 2: if_empty_n=0 after edge 2.
- Fill and overflow, DEPTH=4, DATA_WIDTH=8:
  - Push 0x11, 0x22, 0x33, 0x44: if_full_n=0 after the 4th edge.
  - 5th push of 0x55 is ignored.
  - Four pops yield 0x11, 0x22, 0x33, 0x44 in order, then if_empty_n=0.
- Streaming, DEPTH=4: push and pop every cycle for 100 cycles with an incrementing pattern. Output matches input with 1-cycle lag, count stays at 1, and if_full_n never drops.
- Simultaneous at full, DEPTH=2: while full, assert push (0xAA) and pop together. Pop is accepted and push is rejected. The next head is the second stored token, and 0xAA never appears.
- Macro on, DEPTH=4: `if_num_data_valid` reads 0→1→2→3→4 over four pushes, stays 4 on a rejected push, and is 3 after one pop.
